// File: rtl/dendrite_pkg.sv
// Config register map and state encoding for the dendrite compartment.
package dendrite_pkg;
    localparam logic [2:0] CFG_EL       = 3'd0;
    localparam logic [2:0] CFG_GL_LEAK  = 3'd1;
    localparam logic [2:0] CFG_V_THRESH = 3'd2;
    localparam logic [2:0] CFG_V_RESET  = 3'd3;
    localparam logic [2:0] CFG_TAU_REF  = 3'd4;
    localparam logic [2:0] CFG_CTRL     = 3'd5;

    typedef enum logic [1:0] {
        ST_DISABLED   = 2'd0,
        ST_INTEGRATE  = 2'd1,
        ST_REFRACTORY = 2'd2
    } state_e;
endpackage

// File: rtl/fp_pkg.sv
// Shared fixed-point word definitions used across the neuron datapath.
package fp;
    localparam int WORD_LENGTH = 16;
    typedef logic [WORD_LENGTH-1:0] fpType;
endpackage

// File: rtl/dendrite_compartment_saturating_current_sum.sv
// Sums all synapse currents at full width, applies the scaling shift and
// clamps the result to one word.
module saturating_current_sum #(
    parameter int NUM_SYNAPSES  = 4,
    parameter int CURRENT_SHIFT = 0
) (
    input  logic [NUM_SYNAPSES-1:0][fp::WORD_LENGTH-1:0] syn_current,
    output logic [fp::WORD_LENGTH-1:0]                   current_sum
);
    localparam int W     = fp::WORD_LENGTH;
    localparam int SUM_W = W + $clog2(NUM_SYNAPSES);
    localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'({W{1'b1}});

    logic [SUM_W-1:0] raw_sum_s;
    logic [SUM_W-1:0] shifted_sum_s;

    // Wide accumulation, scaling and clamp to the word range.
    always_comb begin
        raw_sum_s = {SUM_W{1'b0}};
        for (int i = 0; i < NUM_SYNAPSES; i++) begin
            raw_sum_s = raw_sum_s + SUM_W'(syn_current[i]);
        end
        shifted_sum_s = raw_sum_s >> CURRENT_SHIFT;
        if (shifted_sum_s > SAT_MAX) begin
            current_sum = {W{1'b1}};
        end else begin
            current_sum = shifted_sum_s[W-1:0];
        end
    end
endmodule

// File: rtl/dendrite_compartment.sv
// Leaky integrate-and-fire membrane fed by the summed synapse currents;
// vmem is broadcast back to the synapses every cycle.
module dendrite_compartment
    import dendrite_pkg::*;
#(
    parameter int NUM_SYNAPSES  = 4,
    parameter int CURRENT_SHIFT = 0
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic [NUM_SYNAPSES-1:0][fp::WORD_LENGTH-1:0] syn_current,
    output logic [fp::WORD_LENGTH-1:0]                   vmem,
    output logic                                         spike_out,
    output logic                                         refractory,
    input  logic                                         cfg_we,
    input  logic [2:0]                                   cfg_addr,
    input  logic [fp::WORD_LENGTH-1:0]                   cfg_data
);
    localparam int W      = fp::WORD_LENGTH;
    localparam int PW     = W + 2;
    localparam int PROD_W = 2 * W;

    fp::fpType el_r, gl_leak_r, v_thresh_r, v_reset_r, tau_ref_r;
    logic      enable_r;
    logic      enable_next_s;

    state_e    state_r, state_next_s;
    fp::fpType vmem_r, vmem_next_s;
    fp::fpType ref_cnt_r, ref_cnt_next_s;
    logic      spike_r, spike_next_s;
    logic      refractory_r, refractory_next_s;

    fp::fpType          current_sum_s;
    fp::fpType          diff_s;
    logic [PROD_W-1:0]  leak_prod_s;
    fp::fpType          leak_mag_s;
    logic [PW-1:0]      sum_ext_s;
    logic [PW-1:0]      integ_s;
    fp::fpType          vmem_integ_s;

    saturating_current_sum #(
        .NUM_SYNAPSES (NUM_SYNAPSES),
        .CURRENT_SHIFT(CURRENT_SHIFT)
    ) u_current_sum (
        .syn_current(syn_current),
        .current_sum(current_sum_s)
    );

    // Configuration register file; unmapped addresses are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            el_r       <= {W{1'b0}};
            gl_leak_r  <= {W{1'b0}};
            v_thresh_r <= {W{1'b0}};
            v_reset_r  <= {W{1'b0}};
            tau_ref_r  <= {W{1'b0}};
            enable_r   <= 1'b0;
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_EL:       el_r       <= cfg_data;
                CFG_GL_LEAK:  gl_leak_r  <= cfg_data;
                CFG_V_THRESH: v_thresh_r <= cfg_data;
                CFG_V_RESET:  v_reset_r  <= cfg_data;
                CFG_TAU_REF:  tau_ref_r  <= cfg_data;
                CFG_CTRL:     enable_r   <= cfg_data[0];
                default:      enable_r   <= enable_r;
            endcase
        end
    end

    // Enable is decoded from the write itself so enable/disable act on the write edge.
    always_comb begin
        if (cfg_we && (cfg_addr == CFG_CTRL)) begin
            enable_next_s = cfg_data[0];
        end else begin
            enable_next_s = enable_r;
        end
    end

    // Leak toward El plus the input current, clamped to the word range.
    always_comb begin
        if (vmem_r > el_r) begin
            diff_s = vmem_r - el_r;
        end else begin
            diff_s = el_r - vmem_r;
        end
        leak_prod_s = PROD_W'(diff_s) * PROD_W'(gl_leak_r);
        leak_mag_s  = W'(leak_prod_s >> W);
        sum_ext_s   = PW'(vmem_r) + PW'(current_sum_s);
        if (vmem_r > el_r) begin
            integ_s = sum_ext_s - PW'(leak_mag_s);
        end else if (vmem_r < el_r) begin
            integ_s = sum_ext_s + PW'(leak_mag_s);
        end else begin
            integ_s = sum_ext_s;
        end
        if (integ_s[PW-1]) begin
            vmem_integ_s = {W{1'b0}};
        end else if (integ_s > PW'({W{1'b1}})) begin
            vmem_integ_s = {W{1'b1}};
        end else begin
            vmem_integ_s = integ_s[W-1:0];
        end
    end

    // Next-state and next-output logic; disable overrides everything, including a spike.
    always_comb begin
        state_next_s   = state_r;
        vmem_next_s    = vmem_r;
        ref_cnt_next_s = ref_cnt_r;
        spike_next_s   = 1'b0;
        if (!enable_next_s) begin
            state_next_s   = ST_DISABLED;
            ref_cnt_next_s = {W{1'b0}};
        end else begin
            case (state_r)
                ST_DISABLED: begin
                    state_next_s = ST_INTEGRATE;
                    vmem_next_s  = el_r;
                end
                ST_INTEGRATE: begin
                    if (vmem_integ_s >= v_thresh_r) begin
                        vmem_next_s  = v_reset_r;
                        spike_next_s = 1'b1;
                        if (tau_ref_r == {W{1'b0}}) begin
                            state_next_s   = ST_INTEGRATE;
                            ref_cnt_next_s = {W{1'b0}};
                        end else begin
                            state_next_s   = ST_REFRACTORY;
                            ref_cnt_next_s = tau_ref_r;
                        end
                    end else begin
                        vmem_next_s = vmem_integ_s;
                    end
                end
                ST_REFRACTORY: begin
                    vmem_next_s = v_reset_r;
                    if (ref_cnt_r <= W'(1)) begin
                        state_next_s   = ST_INTEGRATE;
                        ref_cnt_next_s = {W{1'b0}};
                    end else begin
                        ref_cnt_next_s = ref_cnt_r - W'(1);
                    end
                end
                default: begin
                    state_next_s   = ST_DISABLED;
                    ref_cnt_next_s = {W{1'b0}};
                end
            endcase
        end
        refractory_next_s = (state_next_s == ST_REFRACTORY);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_DISABLED;
            vmem_r       <= {W{1'b0}};
            ref_cnt_r    <= {W{1'b0}};
            spike_r      <= 1'b0;
            refractory_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            vmem_r       <= vmem_next_s;
            ref_cnt_r    <= ref_cnt_next_s;
            spike_r      <= spike_next_s;
            refractory_r <= refractory_next_s;
        end
    end

    assign vmem       = vmem_r;
    assign spike_out  = spike_r;
    assign refractory = refractory_r;
endmodule

// File: tb/tb_dendrite_compartment.sv
// Directed bench for dendrite_compartment: vector table for the integrate/fire
// run plus hand sequences for disable, leak, saturation and async reset.
module tb_dendrite_compartment;
    localparam logic [2:0] A_EL   = 3'd0;
    localparam logic [2:0] A_GL   = 3'd1;
    localparam logic [2:0] A_TH   = 3'd2;
    localparam logic [2:0] A_VR   = 3'd3;
    localparam logic [2:0] A_TAU  = 3'd4;
    localparam logic [2:0] A_CTRL = 3'd5;

    logic              clk;
    logic              reset;
    logic [3:0][15:0]  syn_current;
    logic [15:0]       vmem;
    logic              spike_out;
    logic              refractory;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [15:0]       cfg_data;

    int total;
    int bad;

    typedef struct {
        logic [15:0] syn0;
        logic [15:0] exp_vmem;
        logic        exp_spike;
        logic        exp_refr;
    } vec_t;

    vec_t vecs[14];

    dendrite_compartment #(
        .NUM_SYNAPSES (4),
        .CURRENT_SHIFT(0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .syn_current(syn_current),
        .vmem       (vmem),
        .spike_out  (spike_out),
        .refractory (refractory),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk3(input string name, input logic [15:0] ev, input logic es, input logic er);
        chk({name, ".vmem"}, vmem, ev);
        chk({name, ".spike"}, {15'd0, spike_out}, {15'd0, es});
        chk({name, ".refr"}, {15'd0, refractory}, {15'd0, er});
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 16'h0000;
    endtask

    task automatic set_all(input logic [15:0] v);
        for (int i = 0; i < 4; i++) syn_current[i] = v;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        vecs[0]  = '{16'h0400, 16'h1400, 1'b0, 1'b0};
        vecs[1]  = '{16'h0400, 16'h1800, 1'b0, 1'b0};
        vecs[2]  = '{16'h0400, 16'h1C00, 1'b0, 1'b0};
        vecs[3]  = '{16'h0400, 16'h0800, 1'b1, 1'b1};
        vecs[4]  = '{16'h0400, 16'h0800, 1'b0, 1'b1};
        vecs[5]  = '{16'h0400, 16'h0800, 1'b0, 1'b1};
        vecs[6]  = '{16'h0400, 16'h0800, 1'b0, 1'b0};
        vecs[7]  = '{16'h0400, 16'h0C00, 1'b0, 1'b0};
        vecs[8]  = '{16'h0400, 16'h1000, 1'b0, 1'b0};
        vecs[9]  = '{16'h0400, 16'h1400, 1'b0, 1'b0};
        vecs[10] = '{16'h0400, 16'h1800, 1'b0, 1'b0};
        vecs[11] = '{16'h0400, 16'h1C00, 1'b0, 1'b0};
        vecs[12] = '{16'h0400, 16'h0800, 1'b1, 1'b1};
        vecs[13] = '{16'h0400, 16'h0800, 1'b0, 1'b1};

        reset    = 1'b1;
        cfg_we   = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 16'h0000;
        set_all(16'h0000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk3("reset", 16'h0000, 1'b0, 1'b0);

        // Not enabled: full-scale current must not move vmem.
        set_all(16'hFFFF);
        repeat (3) tick();
        chk3("disabled_ignore", 16'h0000, 1'b0, 1'b0);
        set_all(16'h0000);

        cfg_write(A_EL, 16'h1000);
        cfg_write(A_GL, 16'h0000);
        cfg_write(A_TH, 16'h2000);
        cfg_write(A_VR, 16'h0800);
        cfg_write(A_TAU, 16'h0003);
        cfg_write(3'd6, 16'h0001);
        chk3("addr6_ignored", 16'h0000, 1'b0, 1'b0);
        syn_current[0] = 16'h0400;
        cfg_write(A_CTRL, 16'h0001);
        chk3("enable_loads_el", 16'h1000, 1'b0, 1'b0);

        for (int i = 0; i < 14; i++) begin
            syn_current[0] = vecs[i].syn0;
            tick();
            chk3($sformatf("vec%0d", i), vecs[i].exp_vmem, vecs[i].exp_spike, vecs[i].exp_refr);
        end

        // Disable with two refractory cycles left.
        cfg_write(A_CTRL, 16'h0000);
        chk3("disable_mid_refr", 16'h0800, 1'b0, 1'b0);
        repeat (3) tick();
        chk3("disabled_frozen", 16'h0800, 1'b0, 1'b0);
        cfg_write(A_CTRL, 16'h0001);
        chk3("reenable_el", 16'h1000, 1'b0, 1'b0);
        tick();
        chk3("resume_1", 16'h1400, 1'b0, 1'b0);
        tick();
        tick();
        chk3("resume_3", 16'h1C00, 1'b0, 1'b0);
        // Disable lands on the edge that would have crossed threshold.
        cfg_write(A_CTRL, 16'h0000);
        chk3("disable_beats_spike", 16'h1C00, 1'b0, 1'b0);
        cfg_write(3'd7, 16'h0001);
        chk3("addr7_ignored", 16'h1C00, 1'b0, 1'b0);

        // Leak run, first forcing a spike with v_thresh = 0.
        set_all(16'h0000);
        cfg_write(A_GL, 16'h8000);
        cfg_write(A_VR, 16'h1800);
        cfg_write(A_TAU, 16'h0000);
        cfg_write(A_TH, 16'h0000);
        cfg_write(A_CTRL, 16'h0001);
        chk3("leak_enable", 16'h1000, 1'b0, 1'b0);
        tick();
        chk3("forced_spike", 16'h1800, 1'b1, 1'b0);
        cfg_write(A_TH, 16'hFFFF);
        chk3("write_uses_old_thresh", 16'h1800, 1'b1, 1'b0);
        tick();
        chk3("leak_1", 16'h1400, 1'b0, 1'b0);
        tick();
        chk3("leak_2", 16'h1200, 1'b0, 1'b0);
        tick();
        chk3("leak_3", 16'h1100, 1'b0, 1'b0);
        tick();
        chk3("leak_4", 16'h1080, 1'b0, 1'b0);

        // Saturation: four full-scale currents must clamp and reach threshold 0xFFFF.
        cfg_write(A_VR, 16'hFFFF);
        chk3("leak_5", 16'h1040, 1'b0, 1'b0);
        set_all(16'hFFFF);
        tick();
        chk3("saturate", 16'hFFFF, 1'b1, 1'b0);

        // Asynchronous reset between edges.
        set_all(16'h0400);
        #3 reset = 1'b1;
        #1;
        chk3("async_reset", 16'h0000, 1'b0, 1'b0);
        tick();
        #1 reset = 1'b0;
        tick();
        tick();
        chk3("after_reset", 16'h0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
